// File: rtl/ucsbece154b_mem_arbiter_if.sv
// Memory-side bus of the I/D arbiter: registered request/write/address/data out, read data and ready back.
// The arbiter is the master; the unified single-port memory is the slave.
interface ucsbece154b_mem_arbiter_if;
  logic        MemReq_o;
  logic        MemWe_o;
  logic [31:0] MemAddr_o;
  logic [31:0] MemWdata_o;
  logic [31:0] MemRdata_i;
  logic        MemReady_i;

  modport master (
    output MemReq_o, MemWe_o, MemAddr_o, MemWdata_o,
    input  MemRdata_i, MemReady_i
  );

  modport slave (
    input  MemReq_o, MemWe_o, MemAddr_o, MemWdata_o,
    output MemRdata_i, MemReady_i
  );
endinterface

// File: rtl/ucsbece154b_mem_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and load/store (D), one transaction at a time.
// D wins ties unless it has taken MAX_D_STREAK grants in a row while fetch was waiting; busy states abort after TIMEOUT cycles.
module ucsbece154b_mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              IReq_i,
  input  logic [31:0]                       IAddr_i,
  input  logic                              IFlush_i,
  output logic [31:0]                       IRdata_o,
  output logic                              IValid_o,
  input  logic                              DReq_i,
  input  logic                              DWe_i,
  input  logic [31:0]                       DAddr_i,
  input  logic [31:0]                       DWdata_i,
  output logic [31:0]                       DRdata_o,
  output logic                              DValid_o,
  ucsbece154b_mem_arbiter_if.master         mem,
  output logic                              StallI_o,
  output logic                              StallD_o,
  output logic                              Err_o
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     i_rdata_q, i_rdata_d;
  logic            i_valid_q, i_valid_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            d_valid_q, d_valid_d;
  logic            err_q, err_d;
  logic            discard_q, discard_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic eff_i, eff_d;

  // A requester whose Valid is high this cycle is finishing, so its held request is not a new one.
  assign eff_i = IReq_i & ~i_valid_q;
  assign eff_d = DReq_i & ~d_valid_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    i_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_valid_d   = 1'b0;
    err_d       = 1'b0;
    discard_d   = discard_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (eff_d && ((streak_q < STREAK_MAX) || !eff_i)) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = DWe_i;
          mem_addr_d  = DAddr_i;
          mem_wdata_d = DWdata_i;
          tmo_d       = '0;
          if (!eff_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (eff_i) begin
          state_d    = I_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = IAddr_i;
          tmo_d      = '0;
          streak_d   = '0;
          discard_d  = IFlush_i;
        end
      end

      I_BUSY, D_BUSY: begin
        if ((state_q == I_BUSY) && IFlush_i) begin
          discard_d = 1'b1;
        end
        // Ready takes precedence over an expiring timeout.
        if (mem.MemReady_i || (tmo_q == TMO_LAST)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          discard_d = 1'b0;
          err_d     = ~mem.MemReady_i;
          if (state_q == I_BUSY) begin
            i_rdata_d = mem.MemReady_i ? mem.MemRdata_i : 32'd0;
            // A flush arriving on the completion cycle still kills the result.
            i_valid_d = ~(discard_q | IFlush_i);
          end else begin
            d_valid_d = 1'b1;
            if (!mem.MemReady_i) begin
              d_rdata_d = 32'd0;
            end else if (!mem_we_q) begin
              d_rdata_d = mem.MemRdata_i;
            end
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      i_rdata_q   <= 32'd0;
      i_valid_q   <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      discard_q   <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      i_valid_q   <= i_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
      discard_q   <= discard_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem.MemReq_o   = mem_req_q;
  assign mem.MemWe_o    = mem_we_q;
  assign mem.MemAddr_o  = mem_addr_q;
  assign mem.MemWdata_o = mem_wdata_q;
  assign IRdata_o       = i_rdata_q;
  assign IValid_o       = i_valid_q;
  assign DRdata_o       = d_rdata_q;
  assign DValid_o       = d_valid_q;
  assign Err_o          = err_q;
  assign StallI_o       = IReq_i & ~i_valid_q;
  assign StallD_o       = DReq_i & ~d_valid_q;

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for the I/D memory arbiter: inputs and memory responses are driven on the falling edge,
// outputs are checked on the falling edge against hand-computed values.
module tb_ucsbece154b_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IReq_i = 1'b0, IFlush_i = 1'b0, IValid_o;
  logic [31:0] IAddr_i = 32'd0, IRdata_o;
  logic        DReq_i = 1'b0, DWe_i = 1'b0, DValid_o;
  logic [31:0] DAddr_i = 32'd0, DWdata_i = 32'd0, DRdata_o;
  logic        StallI_o, StallD_o, Err_o;

  int checks = 0;
  int failures = 0;

  ucsbece154b_mem_arbiter_if mem_if();

  ucsbece154b_mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .IReq_i(IReq_i), .IAddr_i(IAddr_i), .IFlush_i(IFlush_i),
    .IRdata_o(IRdata_o), .IValid_o(IValid_o),
    .DReq_i(DReq_i), .DWe_i(DWe_i), .DAddr_i(DAddr_i), .DWdata_i(DWdata_i),
    .DRdata_o(DRdata_o), .DValid_o(DValid_o),
    .mem(mem_if),
    .StallI_o(StallI_o), .StallD_o(StallD_o), .Err_o(Err_o)
  );

  always #5 clk = ~clk;

  // One line per completed transaction.
  always @(negedge clk) begin
    if (IValid_o) $display("xact I  rdata=%h", IRdata_o);
    if (DValid_o) $display("xact D  rdata=%h err=%0b", DRdata_o, Err_o);
    else if (Err_o) $display("xact err without D valid");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    mem_if.MemReady_i = 1'b0;
    mem_if.MemRdata_i = 32'd0;

    // Reset state
    tick(); tick();
    chk("rst MemReq", 32'(mem_if.MemReq_o), 32'd0);
    chk("rst MemWe", 32'(mem_if.MemWe_o), 32'd0);
    chk("rst MemAddr", mem_if.MemAddr_o, 32'd0);
    chk("rst MemWdata", mem_if.MemWdata_o, 32'd0);
    chk("rst IValid", 32'(IValid_o), 32'd0);
    chk("rst DValid", 32'(DValid_o), 32'd0);
    chk("rst Err", 32'(Err_o), 32'd0);
    chk("rst IRdata", IRdata_o, 32'd0);
    chk("rst DRdata", DRdata_o, 32'd0);
    reset = 1'b0;

    // 1: single fetch
    IReq_i = 1'b1; IAddr_i = 32'h100;
    tick();
    chk("t1 MemReq", 32'(mem_if.MemReq_o), 32'd1);
    chk("t1 MemAddr", mem_if.MemAddr_o, 32'h100);
    chk("t1 MemWe", 32'(mem_if.MemWe_o), 32'd0);
    chk("t1 StallI", 32'(StallI_o), 32'd1);
    chk("t1 IValid early", 32'(IValid_o), 32'd0);
    mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'h00500093;
    tick();
    chk("t1 IValid", 32'(IValid_o), 32'd1);
    chk("t1 IRdata", IRdata_o, 32'h00500093);
    chk("t1 MemReq drop", 32'(mem_if.MemReq_o), 32'd0);
    chk("t1 StallI clear", 32'(StallI_o), 32'd0);
    IReq_i = 1'b0; mem_if.MemReady_i = 1'b0;
    tick();
    chk("t1 IValid pulse", 32'(IValid_o), 32'd0);

    // 2: simultaneous I and D store, D first
    IReq_i = 1'b1; IAddr_i = 32'h100;
    DReq_i = 1'b1; DWe_i = 1'b1; DAddr_i = 32'h200; DWdata_i = 32'hDEADBEEF;
    tick();
    chk("t2 D addr", mem_if.MemAddr_o, 32'h200);
    chk("t2 D we", 32'(mem_if.MemWe_o), 32'd1);
    chk("t2 D wdata", mem_if.MemWdata_o, 32'hDEADBEEF);
    chk("t2 StallD", 32'(StallD_o), 32'd1);
    mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'h12345678;
    tick();
    chk("t2 DValid", 32'(DValid_o), 32'd1);
    chk("t2 DRdata held", DRdata_o, 32'd0);
    chk("t2 idle gap", 32'(mem_if.MemReq_o), 32'd0);
    chk("t2 StallD clear", 32'(StallD_o), 32'd0);
    DReq_i = 1'b0; mem_if.MemReady_i = 1'b0;
    tick();
    chk("t2 I req", 32'(mem_if.MemReq_o), 32'd1);
    chk("t2 I addr", mem_if.MemAddr_o, 32'h100);
    chk("t2 I we", 32'(mem_if.MemWe_o), 32'd0);
    chk("t2 DValid pulse", 32'(DValid_o), 32'd0);
    mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'hAAAA0001;
    tick();
    chk("t2 IValid", 32'(IValid_o), 32'd1);
    chk("t2 IRdata", IRdata_o, 32'hAAAA0001);
    IReq_i = 1'b0; mem_if.MemReady_i = 1'b0;
    tick();

    // 3: streak limit, order D,D,D,D,I,D (loads)
    DWe_i = 1'b0; DAddr_i = 32'h200; IAddr_i = 32'h100;
    IReq_i = 1'b1; DReq_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3 grant D", mem_if.MemAddr_o, 32'h200);
      mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'h3000 + 32'(k);
      tick();
      chk("t3 DValid", 32'(DValid_o), 32'd1);
      chk("t3 DRdata", DRdata_o, 32'h3000 + 32'(k));
      mem_if.MemReady_i = 1'b0; IReq_i = 1'b0; DReq_i = 1'b0;
      tick();
      IReq_i = 1'b1; DReq_i = 1'b1;
    end
    tick();
    chk("t3 grant I at limit", mem_if.MemAddr_o, 32'h100);
    mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'h4444;
    tick();
    chk("t3 IValid", 32'(IValid_o), 32'd1);
    mem_if.MemReady_i = 1'b0; IReq_i = 1'b0; DReq_i = 1'b0;
    tick();
    IReq_i = 1'b1; DReq_i = 1'b1;
    tick();
    chk("t3 grant D after I", mem_if.MemAddr_o, 32'h200);
    mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'h3005;
    tick();
    chk("t3 DValid last", 32'(DValid_o), 32'd1);
    mem_if.MemReady_i = 1'b0; IReq_i = 1'b0; DReq_i = 1'b0;
    tick();

    // 4: flush during I_BUSY, then a normal refetch
    IReq_i = 1'b1; IAddr_i = 32'h104;
    tick();
    chk("t4 grant I", mem_if.MemAddr_o, 32'h104);
    IFlush_i = 1'b1;
    tick();
    IFlush_i = 1'b0;
    chk("t4 busy MemReq", 32'(mem_if.MemReq_o), 32'd1);
    chk("t4 busy StallI", 32'(StallI_o), 32'd1);
    tick();
    chk("t4 busy MemReq 2", 32'(mem_if.MemReq_o), 32'd1);
    mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'hBAD0BAD0;
    tick();
    chk("t4 MemReq done", 32'(mem_if.MemReq_o), 32'd0);
    chk("t4 IValid suppressed", 32'(IValid_o), 32'd0);
    chk("t4 StallI held", 32'(StallI_o), 32'd1);
    chk("t4 IRdata captured", IRdata_o, 32'hBAD0BAD0);
    mem_if.MemReady_i = 1'b0; mem_if.MemRdata_i = 32'h00A00113;
    tick();
    chk("t4 refetch req", 32'(mem_if.MemReq_o), 32'd1);
    chk("t4 refetch no valid", 32'(IValid_o), 32'd0);
    mem_if.MemReady_i = 1'b1;
    tick();
    chk("t4 refetch IValid", 32'(IValid_o), 32'd1);
    chk("t4 refetch IRdata", IRdata_o, 32'h00A00113);
    IReq_i = 1'b0; mem_if.MemReady_i = 1'b0;
    tick();
    // flush in the granting IDLE cycle
    IReq_i = 1'b1; IFlush_i = 1'b1;
    tick();
    IFlush_i = 1'b0; mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'h77;
    tick();
    chk("t4 grant-flush IValid", 32'(IValid_o), 32'd0);
    IReq_i = 1'b0; mem_if.MemReady_i = 1'b0;
    tick();
    chk("t4 grant-flush idle", 32'(mem_if.MemReq_o), 32'd0);

    // 5: timeout abort on a D load, then ready on the last allowed cycle
    DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h300;
    tick();
    chk("t5 cycle 1", 32'(mem_if.MemReq_o), 32'd1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk("t5 busy MemReq", 32'(mem_if.MemReq_o), 32'd1);
      chk("t5 busy Err", 32'(Err_o), 32'd0);
    end
    tick();
    chk("t5 Err", 32'(Err_o), 32'd1);
    chk("t5 DValid", 32'(DValid_o), 32'd1);
    chk("t5 DRdata zero", DRdata_o, 32'd0);
    chk("t5 MemReq drop", 32'(mem_if.MemReq_o), 32'd0);
    DReq_i = 1'b0;
    tick();
    chk("t5 Err pulse", 32'(Err_o), 32'd0);
    chk("t5 DValid pulse", 32'(DValid_o), 32'd0);
    DReq_i = 1'b1;
    tick();
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk("t5b busy MemReq", 32'(mem_if.MemReq_o), 32'd1);
    end
    mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'h55;
    tick();
    chk("t5b no Err", 32'(Err_o), 32'd0);
    chk("t5b DValid", 32'(DValid_o), 32'd1);
    chk("t5b DRdata", DRdata_o, 32'h55);
    DReq_i = 1'b0; mem_if.MemReady_i = 1'b0;
    tick();

    // 6: reset in the middle of D_BUSY
    DReq_i = 1'b1; DAddr_i = 32'h400;
    tick();
    chk("t6 grant D", mem_if.MemAddr_o, 32'h400);
    tick();
    reset = 1'b1; DReq_i = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6 MemReq", 32'(mem_if.MemReq_o), 32'd0);
    chk("t6 MemAddr", mem_if.MemAddr_o, 32'd0);
    chk("t6 DValid", 32'(DValid_o), 32'd0);
    chk("t6 IValid", 32'(IValid_o), 32'd0);
    chk("t6 DRdata", DRdata_o, 32'd0);
    IReq_i = 1'b1; IAddr_i = 32'h108;
    tick();
    chk("t6 I grant", mem_if.MemAddr_o, 32'h108);
    mem_if.MemReady_i = 1'b1; mem_if.MemRdata_i = 32'h99;
    tick();
    chk("t6 IValid", 32'(IValid_o), 32'd1);
    chk("t6 IRdata", IRdata_o, 32'h99);
    IReq_i = 1'b0; mem_if.MemReady_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
